// File: rtl/waveform_sample_generator_pkg.sv
// Shared wave codes, DAC constants and noise LFSR definition for the waveform generator.
package waveform_sample_generator_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW = 2'b00,
      WAVE_TRI = 2'b01,
      WAVE_SQR = 2'b10,
      WAVE_AUX = 2'b11
   } wave_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned DAC_W            = 12;
   localparam logic [11:0] DAC_MIDSCALE     = 12'h800;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_TAP_MASK    = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAP_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/waveform_sample_generator_sine_quarter_rom.sv
// First-quadrant sine table: 64 points at half-step offsets, scaled to 0..2047.
module sine_quarter_rom (
   input  logic [5:0]  addr_i,
   output logic [10:0] data_o
);

   always_comb begin
      data_o = '0;
      case (addr_i)
         6'd0:  data_o = 11'd25;   6'd1:  data_o = 11'd75;   6'd2:  data_o = 11'd126;  6'd3:  data_o = 11'd176;
         6'd4:  data_o = 11'd226;  6'd5:  data_o = 11'd275;  6'd6:  data_o = 11'd325;  6'd7:  data_o = 11'd375;
         6'd8:  data_o = 11'd424;  6'd9:  data_o = 11'd473;  6'd10: data_o = 11'd522;  6'd11: data_o = 11'd570;
         6'd12: data_o = 11'd618;  6'd13: data_o = 11'd666;  6'd14: data_o = 11'd713;  6'd15: data_o = 11'd760;
         6'd16: data_o = 11'd806;  6'd17: data_o = 11'd852;  6'd18: data_o = 11'd898;  6'd19: data_o = 11'd943;
         6'd20: data_o = 11'd987;  6'd21: data_o = 11'd1031; 6'd22: data_o = 11'd1074; 6'd23: data_o = 11'd1116;
         6'd24: data_o = 11'd1158; 6'd25: data_o = 11'd1199; 6'd26: data_o = 11'd1239; 6'd27: data_o = 11'd1279;
         6'd28: data_o = 11'd1318; 6'd29: data_o = 11'd1356; 6'd30: data_o = 11'd1393; 6'd31: data_o = 11'd1430;
         6'd32: data_o = 11'd1465; 6'd33: data_o = 11'd1500; 6'd34: data_o = 11'd1533; 6'd35: data_o = 11'd1566;
         6'd36: data_o = 11'd1598; 6'd37: data_o = 11'd1629; 6'd38: data_o = 11'd1659; 6'd39: data_o = 11'd1688;
         6'd40: data_o = 11'd1716; 6'd41: data_o = 11'd1743; 6'd42: data_o = 11'd1769; 6'd43: data_o = 11'd1793;
         6'd44: data_o = 11'd1817; 6'd45: data_o = 11'd1840; 6'd46: data_o = 11'd1861; 6'd47: data_o = 11'd1881;
         6'd48: data_o = 11'd1901; 6'd49: data_o = 11'd1919; 6'd50: data_o = 11'd1936; 6'd51: data_o = 11'd1951;
         6'd52: data_o = 11'd1966; 6'd53: data_o = 11'd1979; 6'd54: data_o = 11'd1992; 6'd55: data_o = 11'd2003;
         6'd56: data_o = 11'd2012; 6'd57: data_o = 11'd2021; 6'd58: data_o = 11'd2028; 6'd59: data_o = 11'd2035;
         6'd60: data_o = 11'd2039; 6'd61: data_o = 11'd2043; 6'd62: data_o = 11'd2046; 6'd63: data_o = 11'd2047;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/waveform_sample_generator.sv
// Phase-accumulator waveform generator producing one DAC sample per sample_req edge.
// Build option WAVEGEN_SINE_LUT_EN turns wave code 11 into ROM sine (one extra pipeline stage).
module waveform_sample_generator
   import waveform_sample_generator_pkg::*;
#(
   parameter int unsigned PHASE_W   = 16,
   parameter int unsigned SAMPLE_W  = DAC_W,
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic                qzt_clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [1:0]          wave_sel,
   input  logic [PHASE_W-1:0]  phase_inc,
   input  logic                sample_req,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic [PHASE_W-1:0]  phase_out
);

   localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(DAC_MIDSCALE);

   state_e               state_q, state_d;
   logic                 req_q;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [15:0]          lfsr_q, lfsr_d;
   wave_e                sel_q, sel_d;
   logic                 upd_q, upd_d;
   logic [SAMPLE_W-1:0]  sample_q, sample_d;
   logic                 valid_q, valid_d;

   logic                 req_edge;
   logic                 accept;
   logic [SAMPLE_W:0]    p;
   logic [SAMPLE_W-1:0]  shape;
   logic [SAMPLE_W-1:0]  out_val;
   logic                 out_go;

   assign req_edge = sample_req ^ req_q;
   assign accept   = (state_q == ST_RUN) && enable && req_edge;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      lfsr_d  = lfsr_q;
      sel_d   = sel_q;
      upd_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (enable) state_d = ST_RUN;
         ST_RUN:  if (!enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (!enable) begin
         phase_d = '0;
      end else if (accept) begin
         phase_d = phase_q + phase_inc;
         lfsr_d  = lfsr_step(lfsr_q);
         sel_d   = wave_e'(wave_sel);
         upd_d   = 1'b1;
      end
   end

   // Shaping reads the registered phase/LFSR/selection captured on the request cycle.
   assign p = phase_q[PHASE_W-1 -: SAMPLE_W+1];

`ifdef WAVEGEN_SINE_LUT_EN
   logic [5:0]          rom_addr;
   logic [10:0]         rom_data;
   logic [SAMPLE_W-1:0] sine_val;
   logic [SAMPLE_W-1:0] stage_q;
   logic                stage_vld_q;

   assign rom_addr = phase_q[PHASE_W-2] ? ~phase_q[PHASE_W-3 -: 6] : phase_q[PHASE_W-3 -: 6];

   sine_quarter_rom u_rom (
      .addr_i (rom_addr),
      .data_o (rom_data)
   );

   assign sine_val = phase_q[PHASE_W-1] ? MIDSCALE - SAMPLE_W'(rom_data)
                                        : MIDSCALE + SAMPLE_W'(rom_data);
`endif

   always_comb begin
      shape = p[SAMPLE_W:1];
      case (sel_q)
         WAVE_SAW: shape = p[SAMPLE_W:1];
         WAVE_TRI: shape = p[SAMPLE_W] ? ~p[SAMPLE_W-1:0] : p[SAMPLE_W-1:0];
         WAVE_SQR: shape = phase_q[PHASE_W-1] ? '1 : '0;
`ifdef WAVEGEN_SINE_LUT_EN
         default:  shape = sine_val;
`else
         default:  shape = lfsr_q[SAMPLE_W-1:0];
`endif
      endcase
   end

`ifdef WAVEGEN_SINE_LUT_EN
   // Extra stage applies to every waveform so latency does not depend on wave_sel.
   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= MIDSCALE;
         stage_vld_q <= 1'b0;
      end else begin
         stage_vld_q <= enable && upd_q;
         if (enable && upd_q) stage_q <= shape;
      end
   end

   assign out_val = stage_q;
   assign out_go  = stage_vld_q;
`else
   assign out_val = shape;
   assign out_go  = upd_q;
`endif

   always_comb begin
      sample_d = sample_q;
      valid_d  = 1'b0;
      if (!enable) begin
         sample_d = MIDSCALE;
         valid_d  = (sample_q != MIDSCALE);
      end else if (out_go) begin
         sample_d = out_val;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         phase_q  <= '0;
         lfsr_q   <= LFSR_SEED;
         sel_q    <= WAVE_SAW;
         upd_q    <= 1'b0;
         sample_q <= MIDSCALE;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= sample_req;
         phase_q  <= phase_d;
         lfsr_q   <= lfsr_d;
         sel_q    <= sel_d;
         upd_q    <= upd_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign phase_out    = phase_q;

endmodule

// File: tb/tb_waveform_sample_generator.sv
// Self-checking bench for waveform_sample_generator (default build: code 11 = LFSR noise).
module tb_waveform_sample_generator;

   logic        qzt_clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  wave_sel;
   logic [15:0] phase_inc;
   logic        sample_req;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic [15:0] phase_out;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_phase;
   logic [15:0] m_lfsr;
   logic [11:0] m_out;

   logic [11:0] obs_so;
   logic        obs_sv;
   logic [15:0] obs_po;

   waveform_sample_generator #(
      .PHASE_W   (16),
      .SAMPLE_W  (12),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .qzt_clk      (qzt_clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .wave_sel     (wave_sel),
      .phase_inc    (phase_inc),
      .sample_req   (sample_req),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .phase_out    (phase_out)
   );

   always #10 qzt_clk = ~qzt_clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Reference shaping from the phase as a plain number in [0, 65536).
   function automatic logic [11:0] ref_shape(input logic [1:0] sel, input int unsigned ph, input int unsigned lf);
      int unsigned x;
      case (sel)
         2'd0:    return 12'(ph / 16);
         2'd1: begin
            x = ph / 8;
            return 12'((x >= 4096) ? (8191 - x) : x);
         end
         2'd2:    return (ph >= 32768) ? 12'hFFF : 12'h000;
         default: return 12'(lf % 4096);
      endcase
   endfunction

   function automatic int unsigned ref_lfsr(input int unsigned l);
      return (l % 2 == 1) ? ((l / 2) ^ 32'h0000_B400) : (l / 2);
   endfunction

   function automatic logic [11:0] model_accept();
      m_phase = 16'((32'(m_phase) + 32'(phase_inc)) % 65536);
      m_lfsr  = 16'(ref_lfsr(m_lfsr));
      return ref_shape(wave_sel, m_phase, m_lfsr);
   endfunction

   // One clock: optional toggle of sample_req, rising edge, observe on the falling edge.
   task automatic step(input bit tog);
      if (tog) sample_req = ~sample_req;
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      obs_so = sample_out;
      obs_sv = sample_valid;
      obs_po = phase_out;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; sample_req = 1'b0; wave_sel = 2'b00; phase_inc = 16'h0000;
      repeat (3) @(negedge qzt_clk);
      total++;
      if (sample_out !== 12'h800 || sample_valid !== 1'b0 || phase_out !== 16'h0000) begin
         bad++;
         $display("FAIL reset_hold: got out=%h valid=%b phase=%h want 800/0/0000", sample_out, sample_valid, phase_out);
      end
      rst_n = 1'b1;
      m_phase = '0; m_lfsr = 16'hACE1; m_out = 12'h800;
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         total++;
         if (obs_so !== 12'h800 || obs_sv !== 1'b0 || obs_po !== 16'h0000) begin
            bad++;
            $display("FAIL reset_idle[%0d]: got out=%h valid=%b phase=%h want 800/0/0000", k, obs_so, obs_sv, obs_po);
         end
      end
   endtask

   task automatic test_noise();
      logic [11:0] prev;
      prev = '0;
      wave_sel = 2'b11;
      for (int k = 0; k <= 100; k++) begin
         if (k < 100) phase_inc = 16'($urandom);
         step(k < 100);
         if (k > 0) begin
            total++;
            if (obs_so !== prev || obs_sv !== 1'b1) begin
               bad++;
               $display("FAIL noise_sample[%0d]: got out=%h valid=%b want %h/1", k - 1, obs_so, obs_sv, prev);
            end
            m_out = prev;
         end
         if (k == 1) begin
            total++;
            if (obs_so !== 12'h270) begin
               bad++;
               $display("FAIL noise_first: got %h want 270", obs_so);
            end
         end
         if (k < 100) begin
            prev = model_accept();
            total++;
            if (obs_po !== m_phase) begin
               bad++;
               $display("FAIL noise_phase[%0d]: got %h want %h", k, obs_po, m_phase);
            end
         end
      end
      step(1'b0);
      total++;
      if (obs_so !== m_out || obs_sv !== 1'b0) begin
         bad++;
         $display("FAIL noise_tail: got out=%h valid=%b want %h/0", obs_so, obs_sv, m_out);
      end
   endtask

   task automatic test_saw();
      logic [11:0] exp;
      enable = 1'b0;
      step(1'b0);
      total++;
      if (obs_so !== 12'h800 || obs_sv !== (m_out != 12'h800) || obs_po !== 16'h0000) begin
         bad++;
         $display("FAIL saw_park: got out=%h valid=%b phase=%h want 800/%b/0000", obs_so, obs_sv, obs_po, m_out != 12'h800);
      end
      m_phase = '0; m_out = 12'h800;
      enable = 1'b1;
      step(1'b0);
      wave_sel = 2'b00; phase_inc = 16'h1000;
      for (int k = 0; k < 16; k++) begin
         step(1'b1);
         void'(model_accept());
         total++;
         if (obs_po !== 16'((k + 1) * 4096) || obs_sv !== 1'b0) begin
            bad++;
            $display("FAIL saw_phase[%0d]: got phase=%h valid=%b want %h/0", k, obs_po, obs_sv, 16'((k + 1) * 4096));
         end
         step(1'b0);
         exp = 12'(((k + 1) * 256) % 4096);
         total++;
         if (obs_so !== exp || obs_sv !== 1'b1) begin
            bad++;
            $display("FAIL saw_sample[%0d]: got out=%h valid=%b want %h/1", k, obs_so, obs_sv, exp);
         end
         m_out = exp;
         step(1'b0);
         total++;
         if (obs_sv !== 1'b0 || obs_so !== exp) begin
            bad++;
            $display("FAIL saw_pulse[%0d]: got out=%h valid=%b want %h/0", k, obs_so, obs_sv, exp);
         end
      end
   endtask

   task automatic test_tri_sqr();
      logic [11:0] tri_exp [4];
      logic [11:0] sqr_exp [4];
      logic [11:0] exp;
      tri_exp = '{12'h800, 12'hFFF, 12'h7FF, 12'h000};
      sqr_exp = '{12'h000, 12'hFFF, 12'hFFF, 12'h000};
      phase_inc = 16'h4000;
      for (int s = 0; s < 2; s++) begin
         wave_sel = (s == 0) ? 2'b01 : 2'b10;
         for (int k = 0; k < 4; k++) begin
            step(1'b1);
            void'(model_accept());
            step(1'b0);
            exp = (s == 0) ? tri_exp[k] : sqr_exp[k];
            total++;
            if (obs_so !== exp || obs_sv !== 1'b1) begin
               bad++;
               $display("FAIL %s[%0d]: got out=%h valid=%b want %h/1", (s == 0) ? "triangle" : "square", k, obs_so, obs_sv, exp);
            end
            m_out = exp;
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [11:0] exp;
      wave_sel = 2'b00; phase_inc = 16'h1230;
      step(1'b1);
      exp = model_accept();
      step(1'b0);
      total++;
      if (obs_so !== exp || obs_sv !== 1'b1) begin
         bad++;
         $display("FAIL drop_pre: got out=%h valid=%b want %h/1", obs_so, obs_sv, exp);
      end
      m_out = exp;
      enable = 1'b0;
      step(1'b1);
      total++;
      if (obs_so !== 12'h800 || obs_sv !== (m_out != 12'h800) || obs_po !== 16'h0000) begin
         bad++;
         $display("FAIL drop_enter: got out=%h valid=%b phase=%h want 800/%b/0000", obs_so, obs_sv, obs_po, m_out != 12'h800);
      end
      m_phase = '0; m_out = 12'h800;
      for (int k = 0; k < 3; k++) begin
         step(k == 1);
         total++;
         if (obs_so !== 12'h800 || obs_sv !== 1'b0 || obs_po !== 16'h0000) begin
            bad++;
            $display("FAIL drop_idle[%0d]: got out=%h valid=%b phase=%h want 800/0/0000", k, obs_so, obs_sv, obs_po);
         end
      end
      enable = 1'b1;
      step(1'b0);
      total++;
      if (obs_so !== 12'h800 || obs_sv !== 1'b0 || obs_po !== 16'h0000) begin
         bad++;
         $display("FAIL drop_rearm: got out=%h valid=%b phase=%h want 800/0/0000", obs_so, obs_sv, obs_po);
      end
      step(1'b1);
      void'(model_accept());
      total++;
      if (obs_po !== 16'h1230) begin
         bad++;
         $display("FAIL drop_restart_phase: got %h want 1230", obs_po);
      end
      step(1'b0);
      total++;
      if (obs_so !== 12'h123 || obs_sv !== 1'b1) begin
         bad++;
         $display("FAIL drop_restart_sample: got out=%h valid=%b want 123/1", obs_so, obs_sv);
      end
      m_out = 12'h123;
   endtask

   task automatic test_async_reset();
      wave_sel = 2'b00; phase_inc = 16'h0400;
      step(1'b1);
      void'(model_accept());
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (sample_out !== 12'h800 || sample_valid !== 1'b0 || phase_out !== 16'h0000) begin
         bad++;
         $display("FAIL areset_immediate: got out=%h valid=%b phase=%h want 800/0/0000", sample_out, sample_valid, phase_out);
      end
      sample_req = 1'b0;
      #2;
      rst_n = 1'b1;
      m_phase = '0; m_lfsr = 16'hACE1; m_out = 12'h800;
      step(1'b0);
      total++;
      if (obs_so !== 12'h800 || obs_sv !== 1'b0 || obs_po !== 16'h0000) begin
         bad++;
         $display("FAIL areset_after: got out=%h valid=%b phase=%h want 800/0/0000", obs_so, obs_sv, obs_po);
      end
      step(1'b1);
      void'(model_accept());
      step(1'b0);
      total++;
      if (obs_so !== 12'h040 || obs_sv !== 1'b1 || obs_po !== 16'h0400) begin
         bad++;
         $display("FAIL areset_first_req: got out=%h valid=%b phase=%h want 040/1/0400", obs_so, obs_sv, obs_po);
      end
      m_out = 12'h040;
   endtask

   task automatic test_inc_zero();
      logic [11:0] exp;
      wave_sel = 2'b01; phase_inc = 16'h0000;
      for (int k = 0; k < 5; k++) begin
         step(1'b1);
         exp = model_accept();
         step(1'b0);
         total++;
         if (obs_so !== exp || obs_sv !== 1'b1 || obs_po !== m_phase) begin
            bad++;
            $display("FAIL inc_zero[%0d]: got out=%h valid=%b phase=%h want %h/1/%h", k, obs_so, obs_sv, obs_po, exp, m_phase);
         end
         m_out = exp;
      end
   endtask

   // wave_sel/phase_inc are scrambled every cycle; only the request cycle's values may matter.
   task automatic test_stream(input string name, input int n, input int unsigned pct);
      logic        pend;
      logic [11:0] pend_val;
      bit          tog;
      pend = 1'b0; pend_val = '0;
      for (int k = 0; k <= n; k++) begin
         tog = (k < n) && ($urandom_range(99) < pct);
         wave_sel  = 2'($urandom);
         phase_inc = 16'($urandom);
         step(tog);
         if (pend) m_out = pend_val;
         total++;
         if (obs_so !== m_out || obs_sv !== pend) begin
            bad++;
            $display("FAIL %s_sample[%0d]: got out=%h valid=%b want %h/%b", name, k, obs_so, obs_sv, m_out, pend);
         end
         pend = 1'b0;
         if (tog) begin
            pend_val = model_accept();
            pend = 1'b1;
         end
         total++;
         if (obs_po !== m_phase) begin
            bad++;
            $display("FAIL %s_phase[%0d]: got %h want %h", name, k, obs_po, m_phase);
         end
      end
   endtask

   task automatic test_back_to_back();
      test_stream("b2b", 40, 100);
   endtask

   initial begin
      test_reset();
      test_noise();
      test_saw();
      test_tri_sqr();
      test_enable_drop();
      test_async_reset();
      test_inc_zero();
      test_back_to_back();
      test_stream("random", 200, 50);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
